// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator and duty meter.
package pwm_pkg;

    localparam int PWM_CNT_W = 16;

    typedef enum logic [1:0] {
        MEAS_IDLE,
        MEAS_HIGH,
        MEAS_LOW
    } meas_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizer for an asynchronous pin with registered edge detection.
module pwm_in_sync
    import pwm_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            p     <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            p     <= chain[STAGES-1];
        end
    end

    assign s    = chain[STAGES-1];
    assign rise = s & ~p;
    assign fall = ~s & p;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an external PWM input in clk cycles,
// with stuck-high / stuck-low detection by rising-edge timeout.
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 60000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    logic             s;
    logic             rise;
    logic             fall;
    logic             timeout;
    logic             result;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] hi_lat;
    meas_state_t      state;
    meas_state_t      state_nx;

    pwm_in_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(pwm_in),
        .s       (s),
        .rise    (rise),
        .fall    (fall)
    );

    // A rise in the same cycle as the timeout wins.
    assign timeout = (run_cnt == TO_VAL) && !rise;
    assign result  = ena && rise && (state == MEAS_LOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MEAS_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!ena || timeout) begin
            state_nx = MEAS_IDLE;
        end else begin
            unique case (state)
                MEAS_IDLE: if (rise) state_nx = MEAS_HIGH;
                MEAS_HIGH: if (fall) state_nx = MEAS_LOW;
                MEAS_LOW:  if (rise) state_nx = MEAS_HIGH;
                default:   state_nx = MEAS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (!ena) begin
            run_cnt <= '0;
        end else if (rise) begin
            run_cnt <= CNT_W'(1);
        end else if (run_cnt != CNT_MAX) begin
            run_cnt <= run_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_lat <= '0;
        end else if (!ena) begin
            hi_lat <= '0;
        end else if ((state == MEAS_HIGH) && fall) begin
            hi_lat <= run_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= result;
            if (result) begin
                period_cnt <= run_cnt;
                high_cnt   <= hi_lat;
            end
        end
    end

    // Level tracks the pin for as long as the stuck condition is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else if (ena) begin
            if (rise) begin
                stuck <= 1'b0;
            end else if (timeout) begin
                stuck <= 1'b1;
            end
            if (timeout || stuck) begin
                stuck_level <= s;
            end
        end
    end

endmodule
